// File: rtl/ps2_device_tx_pkg.sv
// Shared PS/2 frame constants, transmitter FSM states and the frame builder
// used by the device-side transmitter.
package ps2_device_tx_pkg;

  localparam int   PS2_FRAME_BITS = 11;
  localparam int   PS2_LAST_BIT   = PS2_FRAME_BITS - 1;
  localparam logic PS2_START_BIT  = 1'b0;
  localparam logic PS2_STOP_BIT   = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2,
    ST_GAP  = 2'd3
  } tx_state_e;

  // Bit 0 goes on the wire first: {stop, odd parity, D7..D0, start}.
  function automatic logic [PS2_FRAME_BITS-1:0] build_frame(input logic [7:0] data);
    return {PS2_STOP_BIT, ~^data, data, PS2_START_BIT};
  endfunction

endpackage

// File: rtl/ps2_device_tx_fifo.sv
// Synchronous scan-code FIFO: head is always visible, pop is a strobe.
module ps2_tx_fifo #(
  parameter  int DEPTH = 8,
  parameter  int WIDTH = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic [CNT_W-1:0] count_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             push_ok, pop_ok;

  assign push_ok = push_i && (count_q != CNT_W'(DEPTH));
  assign pop_ok  = pop_i && (count_q != '0);

  // NOTE: storage is deliberately left out of reset; count and pointers alone
  // decide which entries are valid, so flushing them is enough.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wr_data_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign rd_data_o = mem_q[rd_ptr_q];
  assign count_o   = count_q;
  assign empty_o   = (count_q == '0);

endmodule

// File: rtl/ps2_device_tx.sv
// Device-side PS/2 transmitter: emulates a keyboard, serialising queued scan
// codes as 11-bit frames on a self-generated ps2_clk, honouring host inhibit.
module ps2_device_tx
  import ps2_device_tx_pkg::*;
#(
  parameter int HALF_PERIOD = 8,
  parameter int FIFO_DEPTH  = 8,
  parameter int GAP_CYCLES  = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       code_valid,
  input  logic [7:0] code_data,
  output logic       code_ready,
  input  logic       host_inhibit,
  output logic       ps2_clk,
  output logic       ps2_data,
  output logic       busy,
  output logic       frame_done
);

  localparam int TMR_MAX = (HALF_PERIOD > GAP_CYCLES) ? HALF_PERIOD : GAP_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX);
  localparam int FCNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam logic [TMR_W-1:0] HALF_LOAD = TMR_W'(HALF_PERIOD - 1);
  localparam logic [TMR_W-1:0] GAP_LOAD  = TMR_W'(GAP_CYCLES - 1);

  tx_state_e                  state_q, state_d;
  logic [TMR_W-1:0]           tmr_q, tmr_d;
  logic [3:0]                 bit_cnt_q, bit_cnt_d;
  logic [PS2_FRAME_BITS-1:0]  shift_q, shift_d;
  logic                       ps2_clk_q, ps2_clk_d;
  logic                       ps2_data_q, ps2_data_d;
  logic                       frame_done_q, frame_done_d;

  logic              push, pop, fifo_empty, tmr_zero;
  logic [7:0]        fifo_head;
  logic [FCNT_W-1:0] fifo_count;

  assign code_ready = (fifo_count < FCNT_W'(FIFO_DEPTH));
  assign push       = code_valid && code_ready;

  ps2_tx_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push_i    (push),
    .wr_data_i (code_data),
    .pop_i     (pop),
    .rd_data_o (fifo_head),
    .count_o   (fifo_count),
    .empty_o   (fifo_empty)
  );

  assign tmr_zero = (tmr_q == '0);

  // NOTE: every signal gets its hold value before the case so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d      = state_q;
    tmr_d        = tmr_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    ps2_clk_d    = ps2_clk_q;
    ps2_data_d   = ps2_data_q;
    frame_done_d = 1'b0;
    pop          = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty && !host_inhibit) begin
          shift_d    = build_frame(fifo_head);
          ps2_data_d = PS2_START_BIT;
          bit_cnt_d  = '0;
          tmr_d      = HALF_LOAD;
          state_d    = ST_HIGH;
        end
      end
      ST_HIGH, ST_LOW: begin
        // Inhibit abandons the frame without popping, so the byte is resent whole.
        if (host_inhibit) begin
          ps2_clk_d  = 1'b1;
          ps2_data_d = 1'b1;
          tmr_d      = GAP_LOAD;
          state_d    = ST_GAP;
        end else if (!tmr_zero) begin
          tmr_d = tmr_q - TMR_W'(1);
        end else if (state_q == ST_HIGH) begin
          ps2_clk_d = 1'b0;
          tmr_d     = HALF_LOAD;
          state_d   = ST_LOW;
        end else if (bit_cnt_q == 4'(PS2_LAST_BIT)) begin
          ps2_clk_d    = 1'b1;
          ps2_data_d   = 1'b1;
          pop          = 1'b1;
          frame_done_d = 1'b1;
          tmr_d        = GAP_LOAD;
          state_d      = ST_GAP;
        end else begin
          ps2_clk_d  = 1'b1;
          ps2_data_d = shift_q[1];
          shift_d    = {1'b1, shift_q[PS2_FRAME_BITS-1:1]};
          bit_cnt_d  = bit_cnt_q + 4'd1;
          tmr_d      = HALF_LOAD;
          state_d    = ST_HIGH;
        end
      end
      ST_GAP: begin
        if (tmr_zero) state_d = ST_IDLE;
        else          tmr_d   = tmr_q - TMR_W'(1);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values computed above.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      tmr_q        <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '1;
      ps2_clk_q    <= 1'b1;
      ps2_data_q   <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      tmr_q        <= tmr_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      ps2_clk_q    <= ps2_clk_d;
      ps2_data_q   <= ps2_data_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign ps2_clk    = ps2_clk_q;
  assign ps2_data   = ps2_data_q;
  assign frame_done = frame_done_q;
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ps2_device_tx.sv
// Directed self-checking bench for ps2_device_tx; a small line monitor
// decodes frames at ps2_clk falls for comparison with hand-computed words.
module tb_ps2_device_tx;

  localparam int HP        = 8;
  localparam int DEPTH     = 8;
  localparam int GAP       = 16;
  localparam int FRAME_CYC = 22 * HP;
  localparam int SPACING   = 22 * HP + GAP + 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       code_valid = 1'b0;
  logic [7:0] code_data = 8'h00;
  logic       host_inhibit = 1'b0;
  logic       code_ready, ps2_clk, ps2_data, busy, frame_done;

  int checks = 0;
  int errors = 0;

  ps2_device_tx #(.HALF_PERIOD(HP), .FIFO_DEPTH(DEPTH), .GAP_CYCLES(GAP)) dut (
    .clk          (clk),
    .rst          (rst),
    .code_valid   (code_valid),
    .code_data    (code_data),
    .code_ready   (code_ready),
    .host_inhibit (host_inhibit),
    .ps2_clk      (ps2_clk),
    .ps2_data     (ps2_data),
    .busy         (busy),
    .frame_done   (frame_done)
  );

  always #5 clk = ~clk;

  // Line monitor: collects one bit per ps2_clk fall, drops partial frames
  // whenever the transmitter goes idle or is reset.
  int          rx_cnt = 0;
  logic [10:0] rx_word = '0;
  logic [10:0] rx_q[$];
  int          start_q[$];
  int          fd_cnt = 0;
  int          cyc = 0;
  logic        prev_clk = 1'b1;
  logic        prev_busy = 1'b0;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (busy && !prev_busy) start_q.push_back(cyc);
    if (rst || !busy) rx_cnt <= 0;
    else if (prev_clk && !ps2_clk) begin
      if (rx_cnt == 10) begin
        rx_q.push_back({ps2_data, rx_word[9:0]});
        rx_cnt <= 0;
      end else begin
        rx_word[rx_cnt] <= ps2_data;
        rx_cnt <= rx_cnt + 1;
      end
    end
    if (frame_done) fd_cnt <= fd_cnt + 1;
    prev_clk  <= ps2_clk;
    prev_busy <= busy;
  end

  function automatic logic [10:0] exp_frame(input logic [7:0] b);
    return {1'b1, ~^b, b, 1'b0};
  endfunction

  task automatic push(input logic [7:0] b);
    int t = 0;
    @(negedge clk);
    while (!code_ready && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (!code_ready) begin
      checks++; errors++;
      $display("FAIL push_timeout: code_ready=%b required 1", code_ready);
    end
    code_valid = 1'b1;
    code_data  = b;
    @(posedge clk);
    #1 code_valid = 1'b0;
  endtask

  task automatic wait_idle(input int bound);
    int t = 0;
    @(posedge clk); #1;
    while (busy !== 1'b0 && t < bound) begin
      @(posedge clk); #1;
      t++;
    end
    if (busy !== 1'b0) begin
      checks++; errors++;
      $display("FAIL idle_timeout: busy=%b required 0", busy);
    end
  endtask

  task automatic wait_rx(input int target, input int bound);
    int t = 0;
    while (rx_q.size() < target && t < bound) begin
      @(posedge clk); #1;
      t++;
    end
    if (rx_q.size() < target) begin
      checks++; errors++;
      $display("FAIL rx_timeout: frames=%0d required %0d", rx_q.size(), target);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (ps2_clk !== 1'b1)    begin errors++; $display("FAIL reset_ps2_clk: got %b want 1", ps2_clk); end
    checks++; if (ps2_data !== 1'b1)   begin errors++; $display("FAIL reset_ps2_data: got %b want 1", ps2_data); end
    checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done: got %b want 0", frame_done); end
    checks++; if (code_ready !== 1'b1) begin errors++; $display("FAIL reset_code_ready: got %b want 1", code_ready); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_frame_1c;
    int k, n, g, base_rx, base_fd;
    base_rx = rx_q.size();
    base_fd = fd_cnt;
    push(8'h1C);
    @(posedge clk); #1;
    checks++; if (ps2_data !== 1'b0) begin errors++; $display("FAIL latency_start_bit: ps2_data=%b want 0", ps2_data); end
    checks++; if (ps2_clk !== 1'b1)  begin errors++; $display("FAIL latency_clk_high: ps2_clk=%b want 1", ps2_clk); end
    k = 0;
    do begin @(posedge clk); #1; k++; end while (ps2_clk !== 1'b0 && k < 100);
    checks++; if (k != HP) begin errors++; $display("FAIL first_fall_cycles: got %0d want %0d", k, HP); end
    n = k;
    while (frame_done !== 1'b1 && n < 1000) begin @(posedge clk); #1; n++; end
    checks++; if (n != FRAME_CYC) begin errors++; $display("FAIL frame_length: got %0d want %0d", n, FRAME_CYC); end
    checks++; if ({ps2_clk, ps2_data} !== 2'b11) begin errors++; $display("FAIL lines_after_stop: got %b want 11", {ps2_clk, ps2_data}); end
    g = 0;
    while (busy !== 1'b0 && g < 100) begin @(posedge clk); #1; g++; end
    checks++; if (g != GAP) begin errors++; $display("FAIL gap_length: got %0d want %0d", g, GAP); end
    checks++; if (rx_q.size() != base_rx + 1) begin errors++; $display("FAIL frame_1c_count: got %0d want %0d", rx_q.size(), base_rx + 1); end
    else begin
      checks++; if (rx_q[base_rx] !== 11'h438) begin errors++; $display("FAIL frame_1c_bits: got %h want 438", rx_q[base_rx]); end
    end
    checks++; if (fd_cnt != base_fd + 1) begin errors++; $display("FAIL frame_1c_done: got %0d want %0d", fd_cnt - base_fd, 1); end
  endtask

  task automatic test_parity_f0;
    int base_rx;
    base_rx = rx_q.size();
    push(8'hF0);
    wait_rx(base_rx + 1, 600);
    wait_idle(100);
    if (rx_q.size() > base_rx) begin
      checks++; if (rx_q[base_rx] !== 11'h7E0) begin errors++; $display("FAIL frame_f0_bits: got %h want 7e0", rx_q[base_rx]); end
      checks++; if (rx_q[base_rx][9] !== 1'b1) begin errors++; $display("FAIL frame_f0_parity: got %b want 1", rx_q[base_rx][9]); end
    end
  endtask

  task automatic test_back_to_back;
    int base_rx, base_fd, base_s;
    base_rx = rx_q.size();
    base_fd = fd_cnt;
    base_s  = start_q.size();
    push(8'h1C);
    push(8'hF0);
    push(8'h1C);
    wait_rx(base_rx + 3, 1500);
    wait_idle(100);
    checks++;
    if (start_q.size() != base_s + 3) begin
      errors++; $display("FAIL b2b_starts: got %0d want 3", start_q.size() - base_s);
    end else begin
      checks++; if (start_q[base_s+1] - start_q[base_s] != SPACING) begin errors++; $display("FAIL b2b_spacing_12: got %0d want %0d", start_q[base_s+1] - start_q[base_s], SPACING); end
      checks++; if (start_q[base_s+2] - start_q[base_s+1] != SPACING) begin errors++; $display("FAIL b2b_spacing_23: got %0d want %0d", start_q[base_s+2] - start_q[base_s+1], SPACING); end
    end
    if (rx_q.size() >= base_rx + 3) begin
      checks++; if (rx_q[base_rx]   !== 11'h438) begin errors++; $display("FAIL b2b_frame0: got %h want 438", rx_q[base_rx]); end
      checks++; if (rx_q[base_rx+1] !== 11'h7E0) begin errors++; $display("FAIL b2b_frame1: got %h want 7e0", rx_q[base_rx+1]); end
      checks++; if (rx_q[base_rx+2] !== 11'h438) begin errors++; $display("FAIL b2b_frame2: got %h want 438", rx_q[base_rx+2]); end
    end
    checks++; if (fd_cnt != base_fd + 3) begin errors++; $display("FAIL b2b_done_pulses: got %0d want 3", fd_cnt - base_fd); end
  endtask

  task automatic test_fill;
    logic [7:0] codes [9];
    int i, t, base_rx;
    logic rdy;
    codes = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
    base_rx = rx_q.size();
    i = 0;
    t = 0;
    while (i < 9 && t < 3000) begin
      @(negedge clk);
      code_valid = 1'b1;
      code_data  = codes[i];
      rdy = code_ready;
      if (i == 8 && rdy) begin
        checks++; if (frame_done !== 1'b1) begin errors++; $display("FAIL fill_ninth_timing: frame_done=%b want 1", frame_done); end
      end
      @(posedge clk);
      t++;
      if (rdy) begin
        i++;
        if (i == 8) begin
          #1;
          checks++; if (code_ready !== 1'b0) begin errors++; $display("FAIL fill_full_ready: got %b want 0", code_ready); end
        end
      end
    end
    #1 code_valid = 1'b0;
    checks++; if (i != 9) begin errors++; $display("FAIL fill_accepted: got %0d want 9", i); end
    wait_rx(base_rx + 9, 3000);
    wait_idle(100);
    if (rx_q.size() >= base_rx + 9) begin
      for (int j = 0; j < 9; j++) begin
        checks++;
        if (rx_q[base_rx+j] !== exp_frame(codes[j])) begin
          errors++; $display("FAIL fill_frame%0d: got %h want %h", j, rx_q[base_rx+j], exp_frame(codes[j]));
        end
      end
    end
  endtask

  task automatic test_inhibit;
    int nf, t, base_rx, base_fd;
    logic pc;
    base_rx = rx_q.size();
    base_fd = fd_cnt;
    push(8'h5A);
    nf = 0; t = 0; pc = ps2_clk;
    while (nf < 5 && t < 400) begin
      @(posedge clk); #1;
      if (pc && !ps2_clk) nf++;
      pc = ps2_clk;
      t++;
    end
    checks++; if (nf != 5) begin errors++; $display("FAIL inhibit_falls: got %0d want 5", nf); end
    host_inhibit = 1'b1;
    @(posedge clk); #1;
    checks++; if ({ps2_clk, ps2_data} !== 2'b11) begin errors++; $display("FAIL inhibit_lines: got %b want 11", {ps2_clk, ps2_data}); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL inhibit_gap_busy: got %b want 1", busy); end
    repeat (40) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL inhibit_hold_idle: busy=%b want 0", busy); end
    checks++; if (fd_cnt != base_fd) begin errors++; $display("FAIL inhibit_no_done: got %0d want 0", fd_cnt - base_fd); end
    @(negedge clk);
    host_inhibit = 1'b0;
    wait_rx(base_rx + 1, 600);
    wait_idle(100);
    repeat (50) @(posedge clk);
    #1;
    checks++; if (rx_q.size() != base_rx + 1) begin errors++; $display("FAIL inhibit_resend_count: got %0d want 1", rx_q.size() - base_rx); end
    else begin
      checks++; if (rx_q[base_rx] !== 11'h6B4) begin errors++; $display("FAIL inhibit_resend_bits: got %h want 6b4", rx_q[base_rx]); end
    end
    checks++; if (fd_cnt != base_fd + 1) begin errors++; $display("FAIL inhibit_resend_done: got %0d want 1", fd_cnt - base_fd); end
  endtask

  task automatic test_reset_mid;
    int nf, t, base_rx, base_fd;
    logic pc;
    base_rx = rx_q.size();
    base_fd = fd_cnt;
    push(8'h11);
    push(8'h22);
    push(8'h33);
    push(8'h44);
    nf = 0; t = 0; pc = ps2_clk;
    while (nf < 3 && t < 400) begin
      @(posedge clk); #1;
      if (pc && !ps2_clk) nf++;
      pc = ps2_clk;
      t++;
    end
    checks++; if (ps2_clk !== 1'b0) begin errors++; $display("FAIL rstmid_pre_clk: got %b want 0", ps2_clk); end
    rst = 1'b1;
    #1;
    checks++; if ({ps2_clk, ps2_data} !== 2'b11) begin errors++; $display("FAIL rstmid_lines: got %b want 11", {ps2_clk, ps2_data}); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b want 0", busy); end
    checks++; if (code_ready !== 1'b1) begin errors++; $display("FAIL rstmid_flushed: code_ready=%b want 1", code_ready); end
    @(negedge clk);
    rst = 1'b0;
    repeat (700) @(posedge clk);
    #1;
    checks++; if (fd_cnt != base_fd) begin errors++; $display("FAIL rstmid_no_done: got %0d want 0", fd_cnt - base_fd); end
    checks++; if (rx_q.size() != base_rx) begin errors++; $display("FAIL rstmid_no_frames: got %0d want 0", rx_q.size() - base_rx); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_idle: busy=%b want 0", busy); end
  endtask

  initial begin
    test_reset;
    test_frame_1c;
    test_parity_f0;
    test_back_to_back;
    test_fill;
    test_inhibit;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
